// File: rtl/qerv_timer_if.sv
// Wishbone-style register bus between the core and the machine timer.
// The master drives the request fields; the timer returns read data and ack.
interface qerv_timer_if;
    logic        i_wb_cyc;
    logic        i_wb_we;
    logic [1:0]  i_wb_adr;
    logic [31:0] i_wb_dat;
    logic [3:0]  i_wb_sel;
    logic [31:0] o_wb_dat;
    logic        o_wb_ack;

    modport master (
        output i_wb_cyc, i_wb_we, i_wb_adr, i_wb_dat, i_wb_sel,
        input  o_wb_dat, o_wb_ack
    );

    modport slave (
        input  i_wb_cyc, i_wb_we, i_wb_adr, i_wb_dat, i_wb_sel,
        output o_wb_dat, o_wb_ack
    );
endinterface

// File: rtl/qerv_timer.sv
// RISC-V style machine timer: prescaled 32-bit mtime, mtimecmp compare,
// ctrl (EN/IE) and status registers behind a single-cycle-ack register bus.
module qerv_timer #(
    parameter string RESET_STRATEGY = "MINI",
    parameter int    DIV            = 0
) (
    input  logic          i_clk,
    input  logic          i_rst,
    qerv_timer_if.slave   wb,
    output logic          o_mtip
);

    localparam bit RST_ALL = (RESET_STRATEGY != "NONE");
    localparam int PW      = (DIV > 0) ? DIV : 1;

    localparam logic [1:0] A_MTIME  = 2'd0;
    localparam logic [1:0] A_MTCMP  = 2'd1;
    localparam logic [1:0] A_CTRL   = 2'd2;
    localparam logic [1:0] A_STATUS = 2'd3;

    logic [31:0]   mtime;
    logic [31:0]   mtimecmp;
    logic [PW-1:0] presc;
    logic          en;
    logic          ie;
    logic          cmp_hit;
    logic          tick;
    logic          wr;
    logic          wr_mtime;
    logic          wr_mtcmp;
    logic          wr_ctrl;
    logic [31:0]   rd_mux;

    function automatic logic [31:0] merge(input logic [31:0] old_v,
                                          input logic [31:0] new_v,
                                          input logic [3:0]  sel);
        logic [31:0] r;
        r = old_v;
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
        end
        return r;
    endfunction

    always_comb begin
        cmp_hit  = (mtime >= mtimecmp);
        // With DIV = 0 the prescaler is a dummy bit and every enabled cycle ticks
        tick     = en & ((DIV == 0) ? 1'b1 : (&presc));
        wr       = wb.i_wb_cyc & wb.i_wb_we & wb.o_wb_ack & ~i_rst;
        wr_mtime = wr & (wb.i_wb_adr == A_MTIME);
        wr_mtcmp = wr & (wb.i_wb_adr == A_MTCMP);
        wr_ctrl  = wr & (wb.i_wb_adr == A_CTRL);
    end

    always_comb begin
        rd_mux = 32'h0;
        case (wb.i_wb_adr)
            A_MTIME:  rd_mux = mtime;
            A_MTCMP:  rd_mux = mtimecmp;
            A_CTRL:   rd_mux = {30'h0, ie, en};
            A_STATUS: rd_mux = {31'h0, cmp_hit};
            default:  rd_mux = 32'h0;
        endcase
    end

    // Control state: always reset, regardless of RESET_STRATEGY
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wb.o_wb_ack <= 1'b0;
            o_mtip      <= 1'b0;
            en          <= 1'b0;
            ie          <= 1'b0;
        end else begin
            wb.o_wb_ack <= wb.i_wb_cyc & ~wb.o_wb_ack;
            o_mtip      <= ie & cmp_hit;
            if (wr_ctrl && wb.i_wb_sel[0]) begin
                en <= wb.i_wb_dat[0];
                ie <= wb.i_wb_dat[1];
            end
        end
    end

    // Datapath: reset only when RST_ALL; otherwise simply frozen during reset
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            if (RST_ALL) begin
                mtime       <= 32'h0;
                mtimecmp    <= 32'hFFFF_FFFF;
                presc       <= '0;
                wb.o_wb_dat <= 32'h0;
            end
        end else begin
            if (wb.i_wb_cyc && !wb.o_wb_ack) wb.o_wb_dat <= rd_mux;

            if (wr_mtime) begin
                mtime <= merge(mtime, wb.i_wb_dat, wb.i_wb_sel);
                presc <= '0;
            end else begin
                if (tick) mtime <= mtime + 32'd1;
                if (en && (DIV != 0)) presc <= presc + PW'(1);
            end

            if (wr_mtcmp) mtimecmp <= merge(mtimecmp, wb.i_wb_dat, wb.i_wb_sel);
        end
    end

endmodule
